rr_mask_arbiter: RTL and testbench

//   Parametrised N-way round-robin arbiter built on a mask + two-priority-encoder scheme.

---
 rtl/rr_mask_arbiter_if.sv | 36 +++
 rtl/rr_mask_arbiter.sv | 125 ++++++++++++
 tb/tb_rr_mask_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rr_mask_arbiter_if.sv
// Request/grant bundle between N requesters and the round-robin arbiter.
// The master side drives requests and acknowledges; the slave side (the arbiter)
// returns the registered grant and its current rotation pointer.
interface rr_mask_arbiter_if #(
    parameter int N = 4
);
    localparam int IDW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]   req;
    logic           ack;
    logic           lock;
    logic [N-1:0]   grant;
    logic [IDW-1:0] grant_id;
    logic           gnt_valid;
    logic [IDW-1:0] ptr;

    modport master (
        output req,
        output ack,
        output lock,
        input  grant,
        input  grant_id,
        input  gnt_valid,
        input  ptr
    );

    modport slave (
        input  req,
        input  ack,
        input  lock,
        output grant,
        output grant_id,
        output gnt_valid,
        output ptr
    );
endinterface

// File: rtl/rr_mask_arbiter.sv
// N-way round-robin arbiter using a pointer-derived mask and two priority encoders.
// The masked encoder picks the lowest requester at or above ptr; if nothing is
// requesting in that region, the unmasked encoder wraps around to the lowest
// requester overall. The grant is registered and held until acknowledged; an
// acknowledge rotates priority to just past the winner and re-arbitrates in the
// same cycle, so back-to-back grants have no idle bubble. With lock set on the
// acknowledge, a still-requesting owner keeps the grant and ptr stays put.
module rr_mask_arbiter #(
    parameter int N       = 4,
    parameter int LOCK_EN = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    rr_mask_arbiter_if.slave     bus
);
    localparam int IDW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDW-1:0] LAST_ID = IDW'(N - 1);

    typedef enum logic {
        IDLE,
        GRANTED
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   grant_q, grant_d;
    logic [IDW-1:0] id_q, id_d;
    logic [IDW-1:0] ptr_q, ptr_d;

    logic [IDW-1:0] ptr_adv;
    logic [IDW-1:0] arb_ptr;
    logic [N-1:0]   mask;
    logic           masked_any;
    logic [IDW-1:0] masked_id;
    logic [IDW-1:0] raw_id;
    logic [IDW-1:0] win_id;
    logic [N-1:0]   win_onehot;
    logic           lock_eff;
    logic           keep_owner;

    // Pointer the arbiter should use this cycle: the rotated pointer when a grant is being released, else the stored one.
    always_comb begin
        ptr_adv = (id_q == LAST_ID) ? '0 : id_q + 1'b1;
        arb_ptr = (state_q == GRANTED) ? ptr_adv : ptr_q;
    end

    // Masked and wrap-around priority encoders; scanning downwards leaves the lowest set index.
    always_comb begin
        mask       = '0;
        masked_any = 1'b0;
        masked_id  = '0;
        raw_id     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            mask[i] = (IDW'(i) >= arb_ptr);
            if (bus.req[i] && mask[i]) begin
                masked_any = 1'b1;
                masked_id  = IDW'(i);
            end
            if (bus.req[i]) begin
                raw_id = IDW'(i);
            end
        end
        win_id = masked_any ? masked_id : raw_id;
        win_onehot = '0;
        for (int i = 0; i < N; i++) begin
            win_onehot[i] = (IDW'(i) == win_id);
        end
    end

    // Next-state logic: load a winner from IDLE, hold while unacknowledged, rotate or keep on acknowledge.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        id_d       = id_q;
        ptr_d      = ptr_q;
        lock_eff   = (LOCK_EN != 0) && bus.lock;
        keep_owner = lock_eff && bus.req[id_q];
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    grant_d = win_onehot;
                    id_d    = win_id;
                    state_d = GRANTED;
                end
            end
            GRANTED: begin
                if (bus.ack && !keep_owner) begin
                    ptr_d = ptr_adv;
                    if (|bus.req) begin
                        grant_d = win_onehot;
                        id_d    = win_id;
                    end else begin
                        grant_d = '0;
                        id_d    = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                grant_d = '0;
                id_d    = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State, grant and pointer registers; reset clears the grant immediately and restores priority to index 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.grant_id  = id_q;
    assign bus.gnt_valid = |grant_q;
    assign bus.ptr       = ptr_q;
endmodule

// File: tb/tb_rr_mask_arbiter.sv
// Self-checking bench for rr_mask_arbiter: an N=4 and an N=5 instance, each
// shadowed by a behavioural model that picks the first requester found when
// walking circularly from the pointer.
module tb_rr_mask_arbiter;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    int m4_owner = -1;
    int m4_ptr   = 0;
    int m5_owner = -1;
    int m5_ptr   = 0;

    rr_mask_arbiter_if #(.N(4)) a4 ();
    rr_mask_arbiter_if #(.N(5)) a5 ();

    rr_mask_arbiter #(.N(4), .LOCK_EN(1)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (a4.slave)
    );

    rr_mask_arbiter #(.N(5), .LOCK_EN(1)) dut5 (
        .clk   (clk),
        .reset (reset),
        .bus   (a5.slave)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // First requester met when walking circularly from p; -1 if none.
    function automatic int rr_pick(input int n, input int p, input logic [31:0] r);
        for (int k = 0; k < n; k++) begin
            int idx;
            idx = (p + k) % n;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [31:0] owner_vec(input int owner);
        logic [31:0] v;
        v = '0;
        if (owner >= 0) v[owner] = 1'b1;
        return v;
    endfunction

    // One clock edge of the reference behaviour.
    task automatic model_step(input int n, input logic [31:0] r, input bit a, input bit l,
                              inout int owner, inout int p);
        if (owner < 0) begin
            owner = rr_pick(n, p, r);
        end else if (a) begin
            if (!(l && r[owner])) begin
                p     = (owner + 1) % n;
                owner = rr_pick(n, p, r);
            end
        end
    endtask

    // Reference models follow every edge and the asynchronous reset.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m4_owner = -1;
            m4_ptr   = 0;
            m5_owner = -1;
            m5_ptr   = 0;
        end else begin
            model_step(4, 32'(a4.req), a4.ack, a4.lock, m4_owner, m4_ptr);
            model_step(5, 32'(a5.req), a5.ack, a5.lock, m5_owner, m5_ptr);
        end
    end

    // Continuous structural watch: grant never multi-hot, gnt_valid tracks it, N=5 pointer stays in range.
    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if (!$onehot0(a4.grant) || a4.gnt_valid !== (|a4.grant)) begin
                errors++;
                $display("[TB] FAIL onehot4: grant=%b gnt_valid=%b required one-hot/zero and valid==|grant", a4.grant, a4.gnt_valid);
            end
            checks++;
            if (!$onehot0(a5.grant) || a5.gnt_valid !== (|a5.grant) || a5.ptr > 3'd4) begin
                errors++;
                $display("[TB] FAIL onehot5: grant=%b gnt_valid=%b ptr=%0d required one-hot/zero, valid==|grant, ptr<=4", a5.grant, a5.gnt_valid, a5.ptr);
            end
        end
    end

    task automatic apply_stimulus(input logic [3:0] r, input bit a, input bit l);
        a4.req  = r;
        a4.ack  = a;
        a4.lock = l;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus5(input logic [4:0] r, input bit a);
        a5.req  = r;
        a5.ack  = a;
        a5.lock = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        a4.req = '0; a4.ack = 1'b0; a4.lock = 1'b0;
        a5.req = '0; a5.ack = 1'b0; a5.lock = 1'b0;
        reset = 1'b1;
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #2;
        checks++;
        if (a4.grant !== 4'b0000 || a4.gnt_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_grant: grant=%b valid=%b required 0000/0", a4.grant, a4.gnt_valid);
        end
        checks++;
        if (a4.grant_id !== 2'd0 || a4.ptr !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset_id_ptr: id=%0d ptr=%0d required 0/0", a4.grant_id, a4.ptr);
        end
        checks++;
        if (a5.grant !== 5'b00000 || a5.ptr !== 3'd0) begin
            errors++;
            $display("[TB] FAIL reset5: grant=%b ptr=%0d required 00000/0", a5.grant, a5.ptr);
        end
        a4.req = 4'b1111;
        @(posedge clk);
        #1;
        checks++;
        if (a4.grant !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_held: grant=%b required 0000", a4.grant);
        end
        reset = 1'b0;
        apply_stimulus(4'b0011, 1'b0, 1'b0);
        checks++;
        if (a4.grant !== 4'b0001 || a4.ptr !== 2'd0) begin
            errors++;
            $display("[TB] FAIL first_grant: grant=%b ptr=%0d required 0001/0", a4.grant, a4.ptr);
        end
        apply_stimulus(4'b0011, 1'b1, 1'b0);
        checks++;
        if (a4.grant !== 4'b0010 || a4.ptr !== 2'd1) begin
            errors++;
            $display("[TB] FAIL pre_reset_grant: grant=%b ptr=%0d required 0010/1", a4.grant, a4.ptr);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (a4.grant !== 4'b0000 || a4.gnt_valid !== 1'b0 || a4.ptr !== 2'd0 || a4.grant_id !== 2'd0) begin
            errors++;
            $display("[TB] FAIL async_reset: grant=%b valid=%b id=%0d ptr=%0d required 0000/0/0/0", a4.grant, a4.gnt_valid, a4.grant_id, a4.ptr);
        end
        #1;
        reset = 1'b0;
        a4.req = '0;
        a4.ack = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [4];
        logic [1:0] exp_p [4];
        exp_g = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_p = '{2'd1, 2'd2, 2'd3, 2'd0};
        apply_stimulus(4'b1111, 1'b0, 1'b0);
        checks++;
        if (a4.grant !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL rr_first: grant=%b required 0001", a4.grant);
        end
        for (int k = 0; k < 4; k++) begin
            apply_stimulus(4'b1111, 1'b1, 1'b0);
            checks++;
            if (a4.grant !== exp_g[k] || a4.ptr !== exp_p[k]) begin
                errors++;
                $display("[TB] FAIL rr_step%0d: grant=%b ptr=%0d required %b/%0d", k, a4.grant, a4.ptr, exp_g[k], exp_p[k]);
            end
        end
        apply_stimulus(4'b0000, 1'b1, 1'b0);
        checks++;
        if (a4.gnt_valid !== 1'b0 || a4.grant_id !== 2'd0 || a4.ptr !== 2'd1) begin
            errors++;
            $display("[TB] FAIL rr_release: valid=%b id=%0d ptr=%0d required 0/0/1", a4.gnt_valid, a4.grant_id, a4.ptr);
        end
    endtask

    task automatic test_wrap();
        apply_stimulus(4'b0010, 1'b0, 1'b0);
        apply_stimulus(4'b0000, 1'b1, 1'b0);
        checks++;
        if (a4.ptr !== 2'd2 || a4.gnt_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wrap_setup: ptr=%0d valid=%b required 2/0", a4.ptr, a4.gnt_valid);
        end
        apply_stimulus(4'b0011, 1'b0, 1'b0);
        checks++;
        if (a4.grant !== 4'b0001 || a4.ptr !== 2'd2) begin
            errors++;
            $display("[TB] FAIL wrap_grant: grant=%b ptr=%0d required 0001/2", a4.grant, a4.ptr);
        end
        apply_stimulus(4'b0010, 1'b1, 1'b0);
        checks++;
        if (a4.grant !== 4'b0010 || a4.gnt_valid !== 1'b1 || a4.ptr !== 2'd1) begin
            errors++;
            $display("[TB] FAIL wrap_b2b: grant=%b valid=%b ptr=%0d required 0010/1/1", a4.grant, a4.gnt_valid, a4.ptr);
        end
        apply_stimulus(4'b0000, 1'b1, 1'b0);
    endtask

    task automatic test_hold();
        do_reset();
        apply_stimulus(4'b0010, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            apply_stimulus(4'b1100, 1'b0, k[0]);
            checks++;
            if (a4.grant !== 4'b0010 || a4.grant_id !== 2'd1 || a4.ptr !== 2'd0) begin
                errors++;
                $display("[TB] FAIL hold%0d: grant=%b id=%0d ptr=%0d required 0010/1/0", k, a4.grant, a4.grant_id, a4.ptr);
            end
        end
        apply_stimulus(4'b1100, 1'b1, 1'b0);
        checks++;
        if (a4.grant !== 4'b0100 || a4.ptr !== 2'd2) begin
            errors++;
            $display("[TB] FAIL hold_release: grant=%b ptr=%0d required 0100/2", a4.grant, a4.ptr);
        end
        apply_stimulus(4'b0000, 1'b1, 1'b0);
    endtask

    task automatic test_lock();
        do_reset();
        apply_stimulus(4'b0100, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(4'b1111, 1'b1, 1'b1);
            checks++;
            if (a4.grant !== 4'b0100 || a4.ptr !== 2'd0) begin
                errors++;
                $display("[TB] FAIL lock_beat%0d: grant=%b ptr=%0d required 0100/0", k, a4.grant, a4.ptr);
            end
        end
        apply_stimulus(4'b1111, 1'b1, 1'b0);
        checks++;
        if (a4.grant !== 4'b1000 || a4.ptr !== 2'd3) begin
            errors++;
            $display("[TB] FAIL lock_release: grant=%b ptr=%0d required 1000/3", a4.grant, a4.ptr);
        end
        apply_stimulus(4'b0011, 1'b1, 1'b1);
        checks++;
        if (a4.grant !== 4'b0001 || a4.ptr !== 2'd0) begin
            errors++;
            $display("[TB] FAIL lock_dropped: grant=%b ptr=%0d required 0001/0", a4.grant, a4.ptr);
        end
        apply_stimulus(4'b0000, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] ev;
        logic [1:0]  eid;
        do_reset();
        for (int k = 0; k < 300; k++) begin
            apply_stimulus(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                           ($urandom_range(0, 2) == 0));
            ev  = owner_vec(m4_owner);
            eid = (m4_owner < 0) ? 2'd0 : 2'(m4_owner);
            checks++;
            if (a4.grant !== ev[3:0] || a4.grant_id !== eid || a4.ptr !== 2'(m4_ptr)) begin
                errors++;
                $display("[TB] FAIL random%0d: grant=%b id=%0d ptr=%0d required %b/%0d/%0d", k, a4.grant, a4.grant_id, a4.ptr, ev[3:0], eid, m4_ptr);
            end
        end
        apply_stimulus(4'b0000, 1'b1, 1'b0);
    endtask

    task automatic test_fairness_n5();
        int          cnt [5];
        logic [31:0] ev;
        do_reset();
        for (int i = 0; i < 5; i++) cnt[i] = 0;
        apply_stimulus5(5'b11111, 1'b0);
        for (int k = 0; k < 10; k++) begin
            ev = owner_vec(m5_owner);
            checks++;
            if (a5.grant !== ev[4:0] || a5.ptr !== 3'(m5_ptr)) begin
                errors++;
                $display("[TB] FAIL fair_step%0d: grant=%b ptr=%0d required %b/%0d", k, a5.grant, a5.ptr, ev[4:0], m5_ptr);
            end
            if (a5.gnt_valid && a5.grant_id < 3'd5) cnt[a5.grant_id]++;
            apply_stimulus5(5'b11111, 1'b1);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (cnt[i] != 2) begin
                errors++;
                $display("[TB] FAIL fair_count%0d: granted %0d times, required 2", i, cnt[i]);
            end
        end
        apply_stimulus5(5'b00000, 1'b1);
    endtask

    // Test sequence.
    initial begin
        a4.req = '0; a4.ack = 1'b0; a4.lock = 1'b0;
        a5.req = '0; a5.ack = 1'b0; a5.lock = 1'b0;
        $display("[TB] starting rr_mask_arbiter bench");
        test_reset();
        test_round_robin();
        test_wrap();
        test_hold();
        test_lock();
        test_random();
        test_fairness_n5();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
